// File: rtl/vga_pkg.sv
// Shared definitions for the VGA frame reader: default 640x480@60 timing,
// image window defaults and placement, bus widths, and the alignment
// pipeline stage record.
package vga_pkg;

  localparam int unsigned VGA_H_VIS  = 640;
  localparam int unsigned VGA_H_FP   = 16;
  localparam int unsigned VGA_H_SYNC = 96;
  localparam int unsigned VGA_H_BP   = 48;
  localparam int unsigned VGA_H_TOT  = VGA_H_VIS + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

  localparam int unsigned VGA_V_VIS  = 480;
  localparam int unsigned VGA_V_FP   = 10;
  localparam int unsigned VGA_V_SYNC = 2;
  localparam int unsigned VGA_V_BP   = 33;
  localparam int unsigned VGA_V_TOT  = VGA_V_VIS + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  localparam int unsigned VGA_IMG_W  = 256;
  localparam int unsigned VGA_IMG_H  = 256;
  localparam int unsigned VGA_X0     = (VGA_H_VIS - VGA_IMG_W) / 2;
  localparam int unsigned VGA_Y0     = (VGA_V_VIS - VGA_IMG_H) / 2;

  localparam int unsigned VGA_ADDR_W = 16;
  localparam int unsigned VGA_PIX_W  = 32;
  localparam int unsigned VGA_COL_W  = 8;

  // Per-pixel attributes carried alongside the RAM read so they line up with q.
  typedef struct packed {
    logic visible;
    logic in_window;
    logic border;
    logic hsync;
    logic vsync;
    logic frame_start;
  } vga_stage_t;

endpackage

// File: rtl/vga_timing.sv
// Raster timing generator: horizontal/vertical position counters plus the
// visible-region and sync decodes of the current position.
// Ports: clk, reset (async, active high), enable (counters hold when low);
//        h_cnt, v_cnt (registered position); visible_c, hsync_c, vsync_c
//        (combinational decodes of h_cnt/v_cnt, sync active high).
module vga_timing #(
  parameter int unsigned H_VIS  = 640,
  parameter int unsigned H_FP   = 16,
  parameter int unsigned H_SYNC = 96,
  parameter int unsigned H_TOT  = 800,
  parameter int unsigned V_VIS  = 480,
  parameter int unsigned V_FP   = 10,
  parameter int unsigned V_SYNC = 2,
  parameter int unsigned V_TOT  = 525,
  parameter int unsigned HW     = 10,
  parameter int unsigned VW     = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  output logic [HW-1:0] h_cnt,
  output logic [VW-1:0] v_cnt,
  output logic          visible_c,
  output logic          hsync_c,
  output logic          vsync_c
);

  // Position counters; v_cnt steps on each h_cnt wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (enable) begin
      if (h_cnt == HW'(H_TOT - 1)) begin
        h_cnt <= '0;
        if (v_cnt == VW'(V_TOT - 1)) v_cnt <= '0;
        else                         v_cnt <= v_cnt + VW'(1);
      end else begin
        h_cnt <= h_cnt + HW'(1);
      end
    end
  end

  // Region decodes of the current position.
  always_comb begin
    visible_c = (h_cnt < HW'(H_VIS)) && (v_cnt < VW'(V_VIS));
    hsync_c   = (h_cnt >= HW'(H_VIS + H_FP)) && (h_cnt < HW'(H_VIS + H_FP + H_SYNC));
    vsync_c   = (v_cnt >= VW'(V_VIS + V_FP)) && (v_cnt < VW'(V_VIS + V_FP + V_SYNC));
  end

endmodule

// File: rtl/vga_frame_reader.sv
// VGA scan-out of a grayscale frame buffer centred in the visible area.
// Ports: clk, reset (async, active high), enable (freezes counters and all
//        pipeline registers when low); rd_addr/rd_en (frame-buffer read,
//        row-major); pixel (RAM q, bits [7:0] used); r, g, b, hsync_n,
//        vsync_n, blank_n, frame_start (registered video outputs).
// Build option: define VGA_FRAME_BORDER_EN to draw a white one-pixel ring
// just outside the image window.
// The RAM read pipeline is expected to advance on the same enable, so data
// in flight stays paired with its address across a scan pause.
module vga_frame_reader
  import vga_pkg::*;
#(
  parameter int unsigned H_VIS      = VGA_H_VIS,
  parameter int unsigned H_FP       = VGA_H_FP,
  parameter int unsigned H_SYNC     = VGA_H_SYNC,
  parameter int unsigned H_BP       = VGA_H_BP,
  parameter int unsigned V_VIS      = VGA_V_VIS,
  parameter int unsigned V_FP       = VGA_V_FP,
  parameter int unsigned V_SYNC     = VGA_V_SYNC,
  parameter int unsigned V_BP       = VGA_V_BP,
  parameter int unsigned IMG_W      = VGA_IMG_W,
  parameter int unsigned IMG_H      = VGA_IMG_H,
  parameter int unsigned RD_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  output logic [VGA_ADDR_W-1:0] rd_addr,
  output logic                  rd_en,
  input  logic [VGA_PIX_W-1:0]  pixel,
  output logic [VGA_COL_W-1:0]  r,
  output logic [VGA_COL_W-1:0]  g,
  output logic [VGA_COL_W-1:0]  b,
  output logic                  hsync_n,
  output logic                  vsync_n,
  output logic                  blank_n,
  output logic                  frame_start
);

  localparam int unsigned H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW    = $clog2(H_TOT);
  localparam int unsigned VW    = $clog2(V_TOT);
  localparam int unsigned X0    = (H_VIS - IMG_W) / 2;
  localparam int unsigned Y0    = (V_VIS - IMG_H) / 2;

`ifdef VGA_FRAME_BORDER_EN
  localparam logic [VGA_COL_W-1:0] BORDER_COL = '1;
`else
  localparam logic [VGA_COL_W-1:0] BORDER_COL = '0;
`endif

  logic [HW-1:0]          h_cnt;
  logic [VW-1:0]          v_cnt;
  logic                   visible_c, hsync_c, vsync_c;
  logic                   in_window_c;
  logic [31:0]            dx_c, dy_c;
  logic [VGA_ADDR_W-1:0]  win_addr_c;
  vga_stage_t             st0_c;
  vga_stage_t             pipe [RD_LATENCY+1];
  vga_stage_t             last;
  logic [VGA_COL_W-1:0]   colour_c;
  logic                   unused_pixel_bits;

  vga_timing #(
    .H_VIS (H_VIS), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_TOT (H_TOT),
    .V_VIS (V_VIS), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_TOT (V_TOT),
    .HW    (HW),    .VW   (VW)
  ) u_timing (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .h_cnt     (h_cnt),
    .v_cnt     (v_cnt),
    .visible_c (visible_c),
    .hsync_c   (hsync_c),
    .vsync_c   (vsync_c)
  );

  // Window/ring classification and row-major address of the current position.
  always_comb begin
    in_window_c = (h_cnt >= HW'(X0)) && (h_cnt < HW'(X0 + IMG_W)) &&
                  (v_cnt >= VW'(Y0)) && (v_cnt < VW'(Y0 + IMG_H));
    dx_c        = 32'(h_cnt) - X0;
    dy_c        = 32'(v_cnt) - Y0;
    win_addr_c  = VGA_ADDR_W'(dy_c * IMG_W + dx_c);

    st0_c             = '0;
    st0_c.visible     = visible_c;
    st0_c.in_window   = in_window_c;
    // The ring is the window grown by one pixel on every side, minus the window.
    st0_c.border      = visible_c && !in_window_c &&
                        (h_cnt >= HW'(X0 - 1)) && (h_cnt <= HW'(X0 + IMG_W)) &&
                        (v_cnt >= VW'(Y0 - 1)) && (v_cnt <= VW'(Y0 + IMG_H));
    st0_c.hsync       = hsync_c;
    st0_c.vsync       = vsync_c;
    st0_c.frame_start = (h_cnt == '0) && (v_cnt == '0);
  end

  // Address register and attribute delay line matching the RAM latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_addr <= '0;
      rd_en   <= 1'b0;
      for (int unsigned i = 0; i <= RD_LATENCY; i++) pipe[i] <= '0;
    end else if (enable) begin
      rd_en <= in_window_c;
      if (in_window_c) rd_addr <= win_addr_c;
      pipe[0] <= st0_c;
      for (int unsigned i = 1; i <= RD_LATENCY; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign last = pipe[RD_LATENCY];

  // Colour select for the pixel now on q.
  always_comb begin
    colour_c = '0;
    if (last.border)    colour_c = BORDER_COL;
    if (last.in_window) colour_c = pixel[VGA_COL_W-1:0];
  end

  assign unused_pixel_bits = ^pixel[VGA_PIX_W-1:VGA_COL_W];

  // Output register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r           <= '0;
      g           <= '0;
      b           <= '0;
      blank_n     <= 1'b0;
      hsync_n     <= 1'b1;
      vsync_n     <= 1'b1;
      frame_start <= 1'b0;
    end else if (enable) begin
      r           <= colour_c;
      g           <= colour_c;
      b           <= colour_c;
      blank_n     <= last.visible;
      hsync_n     <= ~last.hsync;
      vsync_n     <= ~last.vsync;
      frame_start <= last.frame_start;
    end
  end

endmodule

// File: tb/tb_vga_frame_reader.sv
// Scoreboard bench for vga_frame_reader on a reduced raster so several
// frames fit in a short run. Stimulus tracks the scan position and queues
// the expected outputs; a monitor pops them on every enabled clock edge.
module tb_vga_frame_reader;

  localparam int unsigned HV = 24, HFP = 2, HS = 3, HBP = 3;
  localparam int unsigned VV = 14, VFP = 1, VS = 2, VBP = 2;
  localparam int unsigned HT = HV + HFP + HS + HBP;
  localparam int unsigned VT = VV + VFP + VS + VBP;
  localparam int unsigned IW = 16, IH = 8, RDL = 2;
  localparam int unsigned X0 = (HV - IW) / 2;
  localparam int unsigned Y0 = (VV - IH) / 2;
  localparam int unsigned NPIX = IW * IH;

`ifdef VGA_FRAME_BORDER_EN
  localparam logic [7:0] BORDER_C = 8'hFF;
`else
  localparam logic [7:0] BORDER_C = 8'h00;
`endif

  typedef struct packed {
    logic       blank_n;
    logic       hsync_n;
    logic       vsync_n;
    logic       fs;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } out_t;

  typedef struct packed {
    logic        en;
    logic [15:0] addr;
  } rd_t;

  localparam out_t RST_OUT = '{blank_n: 1'b0, hsync_n: 1'b1, vsync_n: 1'b1,
                               fs: 1'b0, r: 8'h00, g: 8'h00, b: 8'h00};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] rd_addr;
  logic        rd_en;
  logic [31:0] pixel;
  logic [7:0]  r, g, b;
  logic        hsync_n, vsync_n, blank_n, frame_start;

  int tot = 0;
  int bad = 0;

  always #5 clk = ~clk;

  vga_frame_reader #(
    .H_VIS (HV), .H_FP (HFP), .H_SYNC (HS), .H_BP (HBP),
    .V_VIS (VV), .V_FP (VFP), .V_SYNC (VS), .V_BP (VBP),
    .IMG_W (IW), .IMG_H (IH), .RD_LATENCY (RDL)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .rd_addr     (rd_addr),
    .rd_en       (rd_en),
    .pixel       (pixel),
    .r           (r),
    .g           (g),
    .b           (b),
    .hsync_n     (hsync_n),
    .vsync_n     (vsync_n),
    .blank_n     (blank_n),
    .frame_start (frame_start)
  );

  // Frame buffer with an RDL-deep read pipeline sharing the scan enable.
  logic [31:0] mem [NPIX];
  logic [31:0] ram_pipe [RDL];
  always @(posedge clk) begin
    if (enable) begin
      ram_pipe[0] <= mem[rd_addr % NPIX];
      for (int i = 1; i < RDL; i++) ram_pipe[i] <= ram_pipe[i-1];
    end
  end
  assign pixel = ram_pipe[RDL-1];

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    tot++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endfunction

  // Reference: expected video for raster position (h,v).
  function automatic out_t model_out(int h, int v);
    out_t o;
    bit   vis, win, ring;
    int   a;
    vis  = (h < HV) && (v < VV);
    win  = (h >= X0) && (h < X0 + IW) && (v >= Y0) && (v < Y0 + IH);
    ring = ((h == X0 - 1 || h == X0 + IW) && v >= Y0 - 1 && v <= Y0 + IH) ||
           ((v == Y0 - 1 || v == Y0 + IH) && h >= X0 - 1 && h <= X0 + IW);
    o.blank_n = vis;
    o.hsync_n = !((h >= HV + HFP) && (h < HV + HFP + HS));
    o.vsync_n = !((v >= VV + VFP) && (v < VV + VFP + VS));
    o.fs      = (h == 0) && (v == 0);
    o.r       = 8'h00;
    if (vis && ring && !win) o.r = BORDER_C;
    if (win) begin
      a   = (v - Y0) * IW + (h - X0);
      o.r = mem[a][7:0];
    end
    o.g = o.r;
    o.b = o.r;
    return o;
  endfunction

  out_t        oq[$];
  rd_t         rq[$];
  int          mh, mv, last_h, last_v;
  logic [15:0] m_last_addr;

  // Queue expectations for the position consumed at the coming edge.
  task automatic push_pos();
    rd_t rdv;
    bit  win;
    oq.push_back(model_out(mh, mv));
    win = (mh >= X0) && (mh < X0 + IW) && (mv >= Y0) && (mv < Y0 + IH);
    if (win) m_last_addr = 16'((mv - Y0) * IW + (mh - X0));
    rdv.en   = win;
    rdv.addr = m_last_addr;
    rq.push_back(rdv);
    last_h = mh;
    last_v = mv;
    mh++;
    if (mh == HT) begin
      mh = 0;
      mv++;
      if (mv == VT) mv = 0;
    end
  endtask

  task automatic step(input bit en);
    @(negedge clk);
    enable = en;
    if (en) push_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    enable      = 1'b0;
    reset       = 1'b0;
    mh          = 0;
    mv          = 0;
    m_last_addr = '0;
    for (int i = 0; i < RDL + 1; i++) oq.push_back(RST_OUT);
  endtask

  initial begin : stim
    int n;
    for (int i = 0; i < NPIX; i++) mem[i] = $urandom;
    repeat (3) @(negedge clk);
    chk("reset_video", {blank_n, hsync_n, vsync_n, frame_start, r, g, b}, RST_OUT);
    chk("reset_rd_en", rd_en, 1'b0);
    chk("reset_rd_addr", rd_addr, 16'h0);

    // Two and a bit frames with enable held high.
    release_reset();
    repeat (2 * HT * VT + 50) step(1'b1);

    // Pause the scan for 37 cycles inside the window, then random enable.
    n = 0;
    while (!(mh == X0 + 5 && mv == Y0 + 2) && n < 2 * HT * VT) begin
      step(1'b1);
      n++;
    end
    repeat (37) step(1'b0);
    repeat (700) step($urandom_range(0, 3) != 0);

    // Asynchronous reset mid-frame.
    n = 0;
    while (!(mh == 18 && mv == 9) && n < 2 * HT * VT) begin
      step(1'b1);
      n++;
    end
    @(negedge clk);
    #2;
    reset  = 1'b1;
    enable = 1'b0;
    oq.delete();
    rq.delete();
    #1;
    chk("async_reset_video", {blank_n, hsync_n, vsync_n, frame_start, r, g, b}, RST_OUT);
    chk("async_reset_rd_en", rd_en, 1'b0);
    repeat (3) @(negedge clk);
    release_reset();

    n = 0;
    do begin
      step(1'b1);
      n++;
    end while (!frame_start && n < 20);
    chk("frame_start_latency", n, RDL + 2);

    n = 0;
    while (!rd_en && n < 2 * HT * VT) begin
      step(1'b1);
      n++;
    end
    chk("first_rd_en_h", last_h, X0);
    chk("first_rd_en_v", last_v, Y0);
    repeat (HT * VT + 20) step(1'b1);

    repeat (4) step(1'b0);
    chk("video_in_flight", oq.size(), RDL + 1);
    chk("rd_in_flight", rq.size(), 0);

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

  initial begin : mon
    bit          e, rs;
    out_t        o_act, o_exp, last_o;
    rd_t         r_act, r_exp, last_r;
    int          gap, rd_cnt, hl, vl;
    bit          seen_fs;
    logic [15:0] last_rd;
    last_o  = RST_OUT;
    last_r  = '0;
    gap     = 0;
    rd_cnt  = 0;
    hl      = 0;
    vl      = 0;
    seen_fs = 1'b0;
    last_rd = '0;
    forever begin
      @(posedge clk);
      e  = enable;
      rs = reset;
      #1;
      o_act = {blank_n, hsync_n, vsync_n, frame_start, r, g, b};
      r_act = {rd_en, rd_addr};
      if (rs) begin
        chk("reset_hold_video", o_act, RST_OUT);
        chk("reset_hold_rd", r_act, 17'h0);
        last_o  = RST_OUT;
        last_r  = '0;
        seen_fs = 1'b0;
        gap     = 0;
        rd_cnt  = 0;
        hl      = 0;
        vl      = 0;
      end else if (e) begin
        if (oq.size() == 0 || rq.size() == 0) begin
          chk("queue_nonempty", 64'(oq.size() * rq.size()), 64'(1));
        end else begin
          o_exp = oq.pop_front();
          r_exp = rq.pop_front();
          chk("video", o_act, o_exp);
          chk("rd", r_act, r_exp);
          last_o = o_exp;
          last_r = r_exp;
        end
        gap++;
        if (rd_en) begin
          if (rd_cnt == 0 && seen_fs) chk("frame_first_addr", rd_addr, 16'h0);
          rd_cnt++;
          last_rd = rd_addr;
        end
        if (frame_start) begin
          if (seen_fs) begin
            chk("frame_start_period", gap, HT * VT);
            chk("rd_en_per_frame", rd_cnt, NPIX);
            chk("frame_last_addr", last_rd, NPIX - 1);
          end
          seen_fs = 1'b1;
          gap     = 0;
          rd_cnt  = 0;
        end
        if (!hsync_n) hl++;
        else begin
          if (hl != 0) chk("hsync_width", hl, HS);
          hl = 0;
        end
        if (!vsync_n) vl++;
        else begin
          if (vl != 0) chk("vsync_width", vl, VS * HT);
          vl = 0;
        end
      end else begin
        chk("freeze_video", o_act, last_o);
        chk("freeze_rd", r_act, last_r);
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

endmodule
